// File: rtl/stage_if.sv
// Instruction fetch stage: single-outstanding fetch FSM feeding a small buffer toward decode.
// Define STAGE_IF_BUF2_EN for a 2-entry output FIFO; otherwise the buffer is a single register.
//
// state | meaning
// ISSUE | present fetch request for pc_q when the buffer has room
// WAIT  | one request outstanding, waiting for its response
// DRAIN | outstanding response belongs to a flushed path; discard it
// HALT  | fetch stopped after wfi; buffer still drains to decode
module stage_if #(
  parameter int               Width   = 32,
  parameter logic [Width-1:0] ResetPc = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req_valid,
  output logic [Width-1:0] imem_req_addr,
  input  logic             imem_req_ready,
  input  logic             imem_rsp_valid,
  input  logic [31:0]      imem_rsp_data,
  input  logic             redirect_valid,
  input  logic [Width-1:0] redirect_pc,
  input  logic             wfi,
  input  logic             wake,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_pc,
  output logic [31:0]      out_opcode
);

`ifdef STAGE_IF_BUF2_EN
  localparam int Depth = 2;
`else
  localparam int Depth = 1;
`endif

  typedef enum logic [1:0] {ISSUE, WAIT, DRAIN, HALT} state_t;

  state_t           state_q, state_d;
  logic [Width-1:0] pc_q, pc_d;
  logic             halt_q, halt_d;
  logic [1:0]       count_q;
  logic [Width-1:0] head_pc_q;
  logic [31:0]      head_op_q;
  logic             push, pop, flush, free, req_fire;

  assign flush    = redirect_valid;
  assign pop      = (count_q != 2'd0) & out_ready & ~redirect_valid;
  assign free     = (count_q < 2'(Depth)) | pop;
  // Gated by rst so nothing is requested while reset is still held.
  assign imem_req_valid = (state_q == ISSUE) & free & ~redirect_valid & ~rst;
  assign imem_req_addr  = pc_q;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign push     = (state_q == WAIT) & imem_rsp_valid & ~redirect_valid;

  assign out_valid  = (count_q != 2'd0);
  assign out_pc     = head_pc_q;
  assign out_opcode = head_op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= ResetPc;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      halt_q  <= halt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    halt_d  = halt_q;
    if (redirect_valid)  halt_d = 1'b0;
    else if (wake)       halt_d = 1'b0;
    else if (wfi)        halt_d = 1'b1;

    case (state_q)
      ISSUE: begin
        if (redirect_valid)  state_d = req_fire ? DRAIN : ISSUE;
        else if (req_fire)   state_d = WAIT;
        else if (halt_d)     state_d = HALT;
      end
      // A response arriving with a redirect retires the outstanding request,
      // so there is nothing left to drain.
      WAIT, DRAIN: begin
        if (redirect_valid)      state_d = imem_rsp_valid ? ISSUE : DRAIN;
        else if (imem_rsp_valid) state_d = halt_d ? HALT : ISSUE;
      end
      HALT: begin
        if (redirect_valid || wake) state_d = ISSUE;
      end
      default: state_d = ISSUE;
    endcase

    if (state_d == HALT) halt_d = 1'b0;

    if (redirect_valid)  pc_d = {redirect_pc[Width-1:2], 2'b00};
    else if (push)       pc_d = pc_q + Width'(4);
  end

`ifdef STAGE_IF_BUF2_EN
  logic [Width-1:0] tail_pc_q;
  logic [31:0]      tail_op_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      head_pc_q <= '0;
      head_op_q <= '0;
      tail_pc_q <= '0;
      tail_op_q <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_pc_q <= pc_q;
            head_op_q <= imem_rsp_data;
          end else begin
            tail_pc_q <= pc_q;
            tail_op_q <= imem_rsp_data;
          end
          count_q <= count_q + 2'd1;
        end
        2'b01: begin
          head_pc_q <= tail_pc_q;
          head_op_q <= tail_op_q;
          count_q   <= count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_pc_q <= pc_q;
            head_op_q <= imem_rsp_data;
          end else begin
            head_pc_q <= tail_pc_q;
            head_op_q <= tail_op_q;
            tail_pc_q <= pc_q;
            tail_op_q <= imem_rsp_data;
          end
        end
        default: ;
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= 2'd0;
      head_pc_q <= '0;
      head_op_q <= '0;
    end else if (flush) begin
      count_q <= 2'd0;
    end else if (push) begin
      head_pc_q <= pc_q;
      head_op_q <= imem_rsp_data;
      count_q   <= 2'd1;
    end else if (pop) begin
      count_q <= 2'd0;
    end
  end
`endif

endmodule
